// File: rtl/alu_sequencer_if.sv
// Instruction-memory fetch channel between the sequencer (master) and program memory (slave).
// One word is transferred on each cycle where imem_req and imem_ack are both high.
interface alu_sequencer_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/decode/issue controller for the 32-bit ALU: owns the PC, the 16x32 register file
// and the F1/F2 flags, and writes each ALU result back to a register, the flags or the PC.
module alu_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [6:0]  HALT_OP  = 7'd127
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    alu_sequencer_if.master        imem,
    output logic [6:0]             alu_instr,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    output logic [31:0]            alu_reg8,
    output logic [15:0]            alu_value,
    output logic                   alu_highlow,
    output logic                   alu_f1,
    output logic                   alu_f2,
    input  logic [31:0]            alu_c,
    input  logic                   alu_f3,
    input  logic                   alu_addrch,
    input  logic [31:0]            alu_naddr,
    output logic                   halted,
    output logic [31:0]            pc
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 7;
    localparam int unsigned RIDX_W = 4;
    localparam int unsigned VAL_W  = 16;
    localparam int unsigned NREG   = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t              state;
    logic                req_q;
    logic [OP_W-1:0]     ir_op;
    logic [RIDX_W-1:0]   ir_rd;
    logic                f1;
    logic                f2;
    logic [XLEN-1:0]     regs [NREG];

    // Field decode straight off the fetch bus so operands can be registered on the ISSUE entry edge
    logic [OP_W-1:0]     op_f;
    logic [RIDX_W-1:0]   rd_f;
    logic [RIDX_W-1:0]   ra_f;
    logic [RIDX_W-1:0]   rb_f;
    logic [VAL_W-1:0]    val_f;

    assign op_f  = imem.imem_rdata[6:0];
    assign rd_f  = imem.imem_rdata[10:7];
    assign ra_f  = imem.imem_rdata[14:11];
    assign rb_f  = imem.imem_rdata[18:15];
    assign val_f = imem.imem_rdata[31:16];

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            req_q       <= 1'b0;
            pc          <= RESET_PC;
            ir_op       <= '0;
            ir_rd       <= '0;
            f1          <= 1'b0;
            f2          <= 1'b0;
            halted      <= 1'b0;
            alu_instr   <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_reg8    <= '0;
            alu_value   <= '0;
            alu_highlow <= 1'b0;
            alu_f1      <= 1'b0;
            alu_f2      <= 1'b0;
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        req_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (req_q && imem.imem_ack) begin
                        state       <= S_ISSUE;
                        req_q       <= 1'b0;
                        ir_op       <= op_f;
                        ir_rd       <= rd_f;
                        alu_instr   <= op_f;
                        alu_a       <= regs[ra_f];
                        alu_b       <= regs[rb_f];
                        alu_reg8    <= regs[8];
                        alu_value   <= val_f;
                        alu_highlow <= (op_f == 7'd6);
                        alu_f1      <= f1;
                        alu_f2      <= f2;
                    end
                end
                S_ISSUE: begin
                    if (ir_op == HALT_OP) begin
                        state       <= S_HALT;
                        halted      <= 1'b1;
                        alu_instr   <= '0;
                        alu_a       <= '0;
                        alu_b       <= '0;
                        alu_reg8    <= '0;
                        alu_value   <= '0;
                        alu_highlow <= 1'b0;
                        alu_f1      <= 1'b0;
                        alu_f2      <= 1'b0;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_WB;
                end
                // Write-back target depends on opcode class; branches are the only non-sequential PC update
                S_WB: begin
                    if (ir_op <= 7'd7) begin
                        regs[ir_rd] <= alu_c;
                    end
                    if (ir_op >= 7'd8 && ir_op <= 7'd13) begin
                        f2 <= f1;
                        f1 <= alu_f3;
                    end
                    if ((ir_op == 7'd14 || ir_op == 7'd15) && alu_addrch) begin
                        pc <= alu_naddr;
                    end else begin
                        pc <= pc + XLEN'(1);
                    end
                    state <= S_FETCH;
                    req_q <= 1'b1;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: drives the fetch channel by hand and models a small
// registered ALU (add, load low/high, compare, branch) to close the write-back loop.
module tb_alu_sequencer;
    logic        clock;
    logic        reset_n;
    logic        start;
    logic [6:0]  alu_instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_reg8;
    logic [15:0] alu_value;
    logic        alu_highlow;
    logic        alu_f1;
    logic        alu_f2;
    logic [31:0] alu_c;
    logic        alu_f3;
    logic        alu_addrch;
    logic [31:0] alu_naddr;
    logic        halted;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    // A halt word: if ever sampled outside a valid handshake the sequencer would stop
    localparam logic [31:0] JUNK = 32'h0000_007F;

    alu_sequencer_if bus ();

    alu_sequencer #(
        .RESET_PC (32'h0000_0000),
        .HALT_OP  (7'd127)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .imem        (bus),
        .alu_instr   (alu_instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_reg8    (alu_reg8),
        .alu_value   (alu_value),
        .alu_highlow (alu_highlow),
        .alu_f1      (alu_f1),
        .alu_f2      (alu_f2),
        .alu_c       (alu_c),
        .alu_f3      (alu_f3),
        .alu_addrch  (alu_addrch),
        .alu_naddr   (alu_naddr),
        .halted      (halted),
        .pc          (pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered ALU stand-in: op0 add, op5/6 load half, op8 compare-equal, op14 jump, op15 jump-if-F1
    always @(posedge clock) begin
        case (alu_instr)
            7'd0:       alu_c <= alu_a + alu_b;
            7'd5, 7'd6: alu_c <= alu_highlow ? {alu_value, alu_a[15:0]} : {alu_a[31:16], alu_value};
            default:    alu_c <= 32'h0;
        endcase
        alu_f3     <= (alu_instr == 7'd8) ? (alu_a == alu_b) : 1'b0;
        alu_addrch <= (alu_instr == 7'd14) || ((alu_instr == 7'd15) && alu_f1);
        alu_naddr  <= alu_reg8;
    end

    logic [31:0] fetch_addr;
    logic        fetch_unstable;
    logic [6:0]  iss_instr;
    logic [31:0] iss_a;
    logic [31:0] iss_b;
    logic [31:0] iss_reg8;
    logic [15:0] iss_value;
    logic        iss_hl;
    logic        iss_f1;
    logic        iss_f2;
    logic        iss_req;
    logic        iss_halted;
    logic        exec_halted;
    logic        wb_req;
    logic [31:0] wb_pc;

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [3:0] rd,
                                        input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [15:0] value);
        return {value, 16'h0} | {13'h0, rb, ra, rd, op};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Serves one fetch with 'waits' stall cycles, then walks ISSUE/EXEC/WB recording what it sees
    task automatic do_instr(input logic [31:0] w, input int waits);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = JUNK;
        for (int n = 0; n < 20 && bus.imem_req !== 1'b1; n++) step();
        fetch_addr     = (bus.imem_req === 1'b1) ? bus.imem_addr : 32'hxxxx_xxxx;
        fetch_unstable = 1'b0;
        for (int i = 0; i < waits; i++) begin
            step();
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== fetch_addr) fetch_unstable = 1'b1;
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = w;
        step();
        bus.imem_rdata = JUNK;
        iss_instr  = alu_instr;
        iss_a      = alu_a;
        iss_b      = alu_b;
        iss_reg8   = alu_reg8;
        iss_value  = alu_value;
        iss_hl     = alu_highlow;
        iss_f1     = alu_f1;
        iss_f2     = alu_f2;
        iss_req    = bus.imem_req;
        iss_halted = halted;
        step();
        bus.imem_ack = 1'b0;
        exec_halted  = halted;
        step();
        wb_req = bus.imem_req;
        wb_pc  = pc;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        repeat (3) step();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.imem_req); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", halted); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc); end
        checks++; if ({alu_instr, alu_a, alu_b, alu_reg8, alu_value, alu_highlow, alu_f1, alu_f2} !== '0) begin
            errors++; $display("FAIL rst_alu_outs got instr=%h a=%h b=%h r8=%h exp all 0", alu_instr, alu_a, alu_b, alu_reg8);
        end
        reset_n = 1'b1;
        repeat (2) step();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", bus.imem_req); end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL start_req got %b exp 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL start_addr got %h exp 0", bus.imem_addr); end
        do_instr(32'h0, 0);
        checks++; if (wb_pc !== 32'h0) begin errors++; $display("FAIL wb_pc_hold got %h exp 0", wb_pc); end
        checks++; if (pc !== 32'h1 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL pc_step1 got pc=%h req=%b exp pc=1 req=1", pc, bus.imem_req); end
        do_instr(32'h0, 0);
        checks++; if (fetch_addr !== 32'h1) begin errors++; $display("FAIL fetch2_addr got %h exp 1", fetch_addr); end
        checks++; if (pc !== 32'h2 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL pc_step2 got pc=%h req=%b exp pc=2 req=1", pc, bus.imem_req); end
    endtask

    task automatic test_load_add();
        do_instr(enc(7'd5, 4'd1, 4'd0, 4'd0, 16'h1234), 0);
        checks++; if (iss_instr !== 7'd5 || iss_value !== 16'h1234 || iss_hl !== 1'b0) begin
            errors++; $display("FAIL ldlo_issue got op=%0d val=%h hl=%b exp op=5 val=1234 hl=0", iss_instr, iss_value, iss_hl);
        end
        do_instr(enc(7'd6, 4'd1, 4'd1, 4'd0, 16'hABCD), 0);
        checks++; if (iss_a !== 32'h0000_1234 || iss_hl !== 1'b1) begin
            errors++; $display("FAIL ldhi_issue got a=%h hl=%b exp a=00001234 hl=1", iss_a, iss_hl);
        end
        do_instr(enc(7'd0, 4'd2, 4'd1, 4'd1, 16'h0000), 0);
        checks++; if (iss_a !== 32'hABCD_1234 || iss_b !== 32'hABCD_1234) begin
            errors++; $display("FAIL add_operands got a=%h b=%h exp abcd1234 abcd1234", iss_a, iss_b);
        end
        do_instr(enc(7'd0, 4'd3, 4'd2, 4'd0, 16'h0000), 0);
        checks++; if (iss_a !== 32'h579A_2468) begin errors++; $display("FAIL add_result_r2 got %h exp 579a2468", iss_a); end
        checks++; if (pc !== 32'h6) begin errors++; $display("FAIL load_add_pc got %h exp 6", pc); end
    endtask

    task automatic test_branch();
        do_instr(enc(7'd5, 4'd3, 4'd0, 4'd0, 16'h0005), 0);
        do_instr(enc(7'd5, 4'd4, 4'd0, 4'd0, 16'h0005), 0);
        do_instr(enc(7'd5, 4'd8, 4'd0, 4'd0, 16'h0040), 0);
        do_instr(enc(7'd8, 4'd0, 4'd3, 4'd4, 16'h0000), 0);
        checks++; if (iss_a !== 32'h5 || iss_b !== 32'h5) begin errors++; $display("FAIL cmp_eq_operands got a=%h b=%h exp 5 5", iss_a, iss_b); end
        do_instr(enc(7'd15, 4'd0, 4'd0, 4'd0, 16'h0000), 0);
        checks++; if (iss_f1 !== 1'b1 || iss_f2 !== 1'b0) begin errors++; $display("FAIL flags_eq got f1=%b f2=%b exp 1 0", iss_f1, iss_f2); end
        checks++; if (iss_reg8 !== 32'h40) begin errors++; $display("FAIL reg8_out got %h exp 40", iss_reg8); end
        checks++; if (fetch_addr !== 32'hA) begin errors++; $display("FAIL bra_fetch_addr got %h exp a", fetch_addr); end
        checks++; if (bus.imem_addr !== 32'h40 || pc !== 32'h40) begin errors++; $display("FAIL bra_taken got addr=%h pc=%h exp 40", bus.imem_addr, pc); end
        do_instr(enc(7'd5, 4'd4, 4'd0, 4'd0, 16'h0006), 0);
        do_instr(enc(7'd8, 4'd0, 4'd3, 4'd4, 16'h0000), 0);
        checks++; if (iss_b !== 32'h6) begin errors++; $display("FAIL cmp_ne_b got %h exp 6", iss_b); end
        do_instr(enc(7'd15, 4'd0, 4'd0, 4'd0, 16'h0000), 0);
        checks++; if (iss_f1 !== 1'b0 || iss_f2 !== 1'b1) begin errors++; $display("FAIL flags_ne got f1=%b f2=%b exp 0 1", iss_f1, iss_f2); end
        checks++; if (bus.imem_addr !== 32'h43) begin errors++; $display("FAIL bra_not_taken got %h exp 43", bus.imem_addr); end
    endtask

    task automatic test_wait_states();
        do_instr(enc(7'd0, 4'd5, 4'd0, 4'd0, 16'h0000), 3);
        checks++; if (fetch_addr !== 32'h43 || fetch_unstable !== 1'b0) begin
            errors++; $display("FAIL wait_stable got addr=%h unstable=%b exp 43 0", fetch_addr, fetch_unstable);
        end
        checks++; if (iss_instr !== 7'd0 || iss_halted !== 1'b0 || iss_req !== 1'b0) begin
            errors++; $display("FAIL wait_discard got op=%0d halted=%b req=%b exp 0 0 0", iss_instr, iss_halted, iss_req);
        end
        checks++; if (wb_req !== 1'b0 || bus.imem_req !== 1'b1 || pc !== 32'h44) begin
            errors++; $display("FAIL wait_7cyc got wb_req=%b req=%b pc=%h exp 0 1 44", wb_req, bus.imem_req, pc);
        end
    endtask

    task automatic test_halt();
        logic bad;
        do_instr(enc(7'd127, 4'd0, 4'd3, 4'd0, 16'h0000), 0);
        checks++; if (iss_a !== 32'h5 || iss_halted !== 1'b0) begin errors++; $display("FAIL halt_issue got a=%h halted=%b exp 5 0", iss_a, iss_halted); end
        checks++; if (exec_halted !== 1'b1) begin errors++; $display("FAIL halt_latency got %b exp 1", exec_halted); end
        checks++; if (alu_instr !== 7'd0 || alu_a !== 32'h0) begin errors++; $display("FAIL halt_alu_zero got op=%h a=%h exp 0 0", alu_instr, alu_a); end
        bad = 1'b0;
        bus.imem_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            start = i[0];
            step();
            if (bus.imem_req !== 1'b0 || halted !== 1'b1) bad = 1'b1;
        end
        start = 1'b0;
        bus.imem_ack = 1'b0;
        checks++; if (bad !== 1'b0 || pc !== 32'h44) begin errors++; $display("FAIL halt_sticky got bad=%b pc=%h exp 0 44", bad, pc); end
    endtask

    task automatic test_reset_mid_fetch();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_cleared got %b exp 0", halted); end
        start = 1'b1;
        step();
        start = 1'b0;
        do_instr(enc(7'd5, 4'd1, 4'd0, 4'd0, 16'h0077), 0);
        bus.imem_ack = 1'b0;
        step();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h1) begin
            errors++; $display("FAIL pending_fetch got req=%b addr=%h exp 1 1", bus.imem_req, bus.imem_addr);
        end
        reset_n = 1'b0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = enc(7'd5, 4'd2, 4'd0, 4'd0, 16'h0055);
        #1;
        checks++; if (bus.imem_req !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL async_rst_fetch got req=%b pc=%h exp 0 0", bus.imem_req, pc); end
        step();
        step();
        reset_n = 1'b1;
        bus.imem_ack = 1'b0;
        step();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL late_ack_idle got %b exp 0", bus.imem_req); end
        start = 1'b1;
        step();
        start = 1'b0;
        do_instr(enc(7'd0, 4'd6, 4'd1, 4'd2, 16'h0000), 0);
        checks++; if (fetch_addr !== 32'h0 || iss_a !== 32'h0 || iss_b !== 32'h0) begin
            errors++; $display("FAIL rst_fetch_regs got addr=%h a=%h b=%h exp 0 0 0", fetch_addr, iss_a, iss_b);
        end
    endtask

    task automatic test_reset_mid_wb();
        do_instr(enc(7'd5, 4'd3, 4'd0, 4'd0, 16'h0009), 0);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = enc(7'd8, 4'd0, 4'd3, 4'd3, 16'h0000);
        step();
        bus.imem_ack = 1'b0;
        bus.imem_rdata = JUNK;
        step();
        step();
        checks++; if (pc !== 32'h2 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL in_wb got pc=%h req=%b exp 2 0", pc, bus.imem_req); end
        reset_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h0 || alu_a !== 32'h0 || bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL async_rst_wb got pc=%h a=%h req=%b exp 0 0 0", pc, alu_a, bus.imem_req);
        end
        step();
        reset_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        do_instr(enc(7'd15, 4'd0, 4'd3, 4'd0, 16'h0000), 0);
        checks++; if (fetch_addr !== 32'h0 || iss_f1 !== 1'b0 || iss_f2 !== 1'b0 || iss_a !== 32'h0) begin
            errors++; $display("FAIL rst_wb_nowrite got addr=%h f1=%b f2=%b a=%h exp 0 0 0 0", fetch_addr, iss_f1, iss_f2, iss_a);
        end
        checks++; if (pc !== 32'h1) begin errors++; $display("FAIL rst_wb_pc got %h exp 1", pc); end
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_branch();
        test_wait_states();
        test_halt();
        test_reset_mid_fetch();
        test_reset_mid_wb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation time limit");
    end
endmodule
